// File: rtl/bbox_crop_scaler.sv
// Crops the latched bounding box out of image memory, nearest-neighbour scales it to
// a 2**LOG2_OUT square and streams one R+G+B intensity per output pixel (valid/ready).
module bbox_crop_scaler #(
  parameter int WIDTH    = 100,
  parameter int HEIGHT   = 100,
  parameter int LOG2_OUT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  output logic [23:0] addr,
  input  logic [15:0] rddata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        empty_box
);

  if (WIDTH * HEIGHT * 3 > (1 << 24)) begin : g_size_check
    $error("image does not fit the 24-bit address space");
  end

  localparam logic [23:0] COL_STRIDE = 24'(HEIGHT * 3);

  typedef enum logic [2:0] {IDLE, CALC, RD_R, RD_G, RD_B, ACC_B, EMIT, DONE} state_t;
  state_t state;

  logic [10:0]         x0, x1, y0, y1;
  logic [LOG2_OUT-1:0] ox, oy;
  logic [23:0]         base;
  logic [17:0]         acc;

  logic [11:0]          bw, bh, sx, sy;
  logic [LOG2_OUT+11:0] px, py;
  logic [23:0]          base_c;
  logic [17:0]          acc_sum;
  logic [15:0]          acc_sat;
  logic                 at_last;

  // Source coordinate = box origin + floor(o * box_size / OUT); never exceeds the far edge.
  assign bw      = {1'b0, x1} - {1'b0, x0} + 12'd1;
  assign bh      = {1'b0, y1} - {1'b0, y0} + 12'd1;
  assign px      = {12'b0, ox} * {{LOG2_OUT{1'b0}}, bw};
  assign py      = {12'b0, oy} * {{LOG2_OUT{1'b0}}, bh};
  assign sx      = {1'b0, x0} + px[LOG2_OUT +: 12];
  assign sy      = {1'b0, y0} + py[LOG2_OUT +: 12];
  assign base_c  = 24'(sx) * COL_STRIDE + 24'(sy) * 24'd3;
  assign acc_sum = acc + {2'b00, rddata};
  assign acc_sat = (acc_sum[17:16] != 2'b00) ? 16'hFFFF : acc_sum[15:0];
  assign at_last = (&ox) && (&oy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      addr      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      empty_box <= 1'b0;
      ox        <= '0;
      oy        <= '0;
      acc       <= '0;
      base      <= '0;
      x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          x0 <= xMin; x1 <= xMax; y0 <= yMin; y1 <= yMax;
          empty_box <= (xMin > xMax) || (yMin > yMax);
          ox    <= '0;
          oy    <= '0;
          done  <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          acc  <= '0;
          base <= base_c;
          if (empty_box) begin
            out_data  <= '0;
            addr      <= '0;
            out_valid <= 1'b1;
            out_last  <= at_last;
            state     <= EMIT;
          end else begin
            addr  <= base_c;
            state <= RD_R;
          end
        end
        // Memory returns data one cycle after addr, so each add lags its address by one state.
        RD_R: begin
          addr  <= base + 24'd1;
          state <= RD_G;
        end
        RD_G: begin
          acc   <= acc_sum;
          addr  <= base + 24'd2;
          state <= RD_B;
        end
        RD_B: begin
          acc   <= acc_sum;
          state <= ACC_B;
        end
        ACC_B: begin
          acc       <= acc_sum;
          out_data  <= acc_sat;
          out_valid <= 1'b1;
          out_last  <= at_last;
          state     <= EMIT;
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (at_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ox <= ox + 1'b1;
            if (&ox) oy <= oy + 1'b1;
            state <= CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
